// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid/ready register chain with bubble collapsing, flush and occupancy count
// Ports: clk/reset (async, active-high), flush (sync clear of all valids),
//   in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream),
//   count (number of valid stages).
module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] v_q, v_d, rdy, pv;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [WIDTH-1:0] pd  [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             acc, emit;
  // A stage can load when it is empty or everything downstream can move;
  // the accumulator keeps rdy free of bit-to-bit self dependence.
  always_comb begin
    logic r;
    r = out_ready;
    rdy = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      r = !v_q[i] | r;
      rdy[i] = r;
    end
  end
  assign in_ready  = rdy[0] & !flush;
  assign out_valid = v_q[DEPTH-1] & !flush;
  assign out_data  = d_q[DEPTH-1];
  assign acc       = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign count     = count_q;
  always_comb begin
    pv = (v_q << 1) | DEPTH'(acc);
    pd[0] = in_data;
    for (int i = 1; i < DEPTH; i++) pd[i] = d_q[i-1];
    for (int i = 0; i < DEPTH; i++) begin
      v_d[i] = !flush & (rdy[i] ? pv[i] : v_q[i]);
      d_d[i] = (!flush & rdy[i] & pv[i]) ? pd[i] : d_q[i];
    end
    count_d = flush ? '0 : count_q + CW'(acc) - CW'(emit);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= RESET_VAL;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
    end
  end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: scoreboard bench for the 8-bit, 4-stage register chain
module tb_pipe_reg_chain;
  logic       clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] count;
  int total, bad, cyc, acc01, acc10, emit01;
  logic [7:0] sb [$];

  pipe_reg_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake pops the oldest accepted word.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out got=%0h exp=none", out_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        check("out_data", {24'h0, out_data}, {24'h0, e});
        if (out_data == 8'h01) emit01 = cyc;
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold in_valid until the chain accepts; in_valid stays high on return.
  task automatic push(input logic [7:0] x);
    bit ok;
    ok = 0;
    in_valid = 1;
    in_data = x;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        sb.push_back(x);
        if (x == 8'h01) acc01 = cyc;
        if (x == 8'h10) acc10 = cyc;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("push_timeout", 32'(x), 32'hFFFF_FFFF);
  endtask

  task automatic drain();
    int n;
    in_valid = 0;
    out_ready = 1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 40) begin
      step(1);
      n++;
    end
    check("drain_done", {31'h0, (sb.size() == 0 && !out_valid)}, 32'd1);
    check("drain_count", {29'h0, count}, 32'd0);
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
    total = 0; bad = 0; cyc = 0; acc01 = 0; acc10 = 0; emit01 = 0;
    #12;
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_count", {29'h0, count}, 32'd0);
    check("rst_out_data", {24'h0, out_data}, 32'h0);
    @(posedge clk);
    #1 reset = 0;

    // Streaming with out_ready high: 0x01..0x10 back to back.
    out_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      if (i == 8) begin
        check("stream_count", {29'h0, count}, 32'd4);
        check("full_in_ready", {31'h0, in_ready}, 32'd1);
      end
    end
    drain();
    check("latency", 32'(emit01 - acc01), 32'd4);
    check("throughput", 32'(acc10 - acc01), 32'd15);

    // Back-pressure: four words fill the chain, the fifth is refused.
    out_ready = 0;
    for (int i = 1; i <= 4; i++) push(8'hA0 + 8'(i));
    in_data = 8'hA5;
    check("bp_count", {29'h0, count}, 32'd4);
    check("bp_in_ready", {31'h0, in_ready}, 32'd0);
    check("bp_out_valid", {31'h0, out_valid}, 32'd1);
    check("bp_out_data", {24'h0, out_data}, 32'hA1);
    step(3);
    check("bp_hold_data", {24'h0, out_data}, 32'hA1);
    check("bp_hold_count", {29'h0, count}, 32'd4);
    out_ready = 1;
    push(8'hA5);
    push(8'hA6);
    drain();

    // Bubble collapse under a stalled output.
    out_ready = 0;
    push(8'h11);
    in_valid = 0;
    step(2);
    push(8'h22);
    in_valid = 0;
    step(3);
    check("bub_count", {29'h0, count}, 32'd2);
    check("bub_in_ready", {31'h0, in_ready}, 32'd1);
    check("bub_out_data", {24'h0, out_data}, 32'h11);
    drain();

    // Flush with three words held.
    out_ready = 0;
    push(8'h31); push(8'h32); push(8'h33);
    in_valid = 0;
    step(1);
    check("fl_pre_valid", {31'h0, out_valid}, 32'd1);
    check("fl_pre_count", {29'h0, count}, 32'd3);
    flush = 1;
    #1;
    check("fl_in_ready", {31'h0, in_ready}, 32'd0);
    check("fl_out_valid", {31'h0, out_valid}, 32'd0);
    @(posedge clk);
    sb.delete();
    #1 flush = 0;
    check("fl_count", {29'h0, count}, 32'd0);
    check("fl_after_valid", {31'h0, out_valid}, 32'd0);
    out_ready = 1;
    push(8'h5A);
    in_valid = 0;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      check("fl_5a_valid", {31'h0, out_valid}, {31'h0, i == 3});
    end
    check("fl_5a_data", {24'h0, out_data}, 32'h5A);
    drain();

    // Asynchronous reset in mid-cycle with a full chain.
    out_ready = 0;
    for (int i = 1; i <= 4; i++) push(8'hC0 + 8'(i));
    in_valid = 0;
    check("ar_full", {29'h0, count}, 32'd4);
    #2 reset = 1;
    #1;
    check("ar_out_valid", {31'h0, out_valid}, 32'd0);
    check("ar_count", {29'h0, count}, 32'd0);
    check("ar_out_data", {24'h0, out_data}, 32'h0);
    sb.delete();
    @(posedge clk);
    #1 reset = 0;
    check("ar_in_ready", {31'h0, in_ready}, 32'd1);
    out_ready = 1;
    push(8'hD1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
